vram_arbiter: RTL and testbench

Shares one single-port video RAM (320×240, 8-bit pixels, 2×2 scaled to 640×480) between the display fetch path and a host read/write port. It sits between the VGA sync generator and the RAM macro. Display fetches always win their slot. The host gets every remaining cycle. Sync and blanking are delayed so that pixel data stays aligned with them at the monitor.

---
 rtl/vga_pkg.sv | 11 +
 rtl/fb_addr_gen.sv | 20 ++
 rtl/vram_arbiter.sv | 96 +++++++++
 tb/tb_vram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the 320x240 framebuffer video path.
// Display timing is 640x480 with each word shown as a 2x2 block.
package vga_pkg;
  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int ADDR_W    = 17;
  localparam int DATA_W    = 8;
  localparam int VIDEO_LAT = 2;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
endpackage

// File: rtl/fb_addr_gen.sv
// Maps a screen coordinate to its framebuffer word address.
// Row stride 320 is built as x256 + x64 to avoid a multiplier.
module fb_addr_gen
  import vga_pkg::*;
#(
  parameter int AW = ADDR_W
) (
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  output logic [AW-1:0] addr
);

  logic [AW-1:0] row;
  logic [AW-1:0] col;

  assign row  = AW'(pixel_y[9:1]);
  assign col  = AW'(pixel_x[9:1]);
  assign addr = (row << 8) + (row << 6) + col;

endmodule

// File: rtl/vram_arbiter.sv
// Shares one single-port VRAM between display fetch and a host port.
// Display slots always win; sync and blank are delayed to match pixels.
module vram_arbiter #(
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              p_tick,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              video_on,
  input  logic              h_sync,
  input  logic              v_sync,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] rgb_o,
  output logic              hsync_o,
  output logic              vsync_o
);
  import vga_pkg::*;

  localparam int FB_WORDS = FB_W * FB_H;

  logic              slot;
  logic              in_range;
  logic              host_acc;
  logic              slot_d;
  logic              rd_pend;
  logic              rd_oob;
  logic [DATA_W-1:0] pix_reg;
  logic [ADDR_W-1:0] disp_addr;
  logic [VIDEO_LAT-1:0] hs_d;
  logic [VIDEO_LAT-1:0] vs_d;
  logic [VIDEO_LAT-1:0] vo_d;

  fb_addr_gen #(
    .AW(ADDR_W)
  ) u_addr (
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .addr   (disp_addr)
  );

  assign slot     = p_tick & video_on & ~pixel_x[0] & ~reset;
  assign in_range = host_addr < ADDR_W'(FB_WORDS);
  assign host_gnt = host_req & ~slot & ~reset;
  assign host_acc = host_gnt & in_range;

  assign ram_en    = slot | host_acc;
  assign ram_we    = host_acc & host_we;
  assign ram_addr  = slot ? disp_addr : host_addr;
  assign ram_wdata = host_wdata;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      slot_d  <= 1'b0;
      rd_pend <= 1'b0;
      rd_oob  <= 1'b0;
      pix_reg <= '0;
      hs_d    <= '1;
      vs_d    <= '1;
      vo_d    <= '0;
    end else begin
      slot_d  <= slot;
      rd_pend <= host_gnt & ~host_we;
      rd_oob  <= ~in_range;
      if (slot_d)
        pix_reg <= ram_rdata;
      hs_d <= {hs_d[VIDEO_LAT-2:0], h_sync};
      vs_d <= {vs_d[VIDEO_LAT-2:0], v_sync};
      vo_d <= {vo_d[VIDEO_LAT-2:0], video_on};
    end
  end

  // Out-of-range reads never touched the RAM, so their data is forced to 0.
  assign host_rvalid = rd_pend;
  assign host_rdata  = (rd_pend & ~rd_oob) ? ram_rdata : '0;

  assign rgb_o   = vo_d[VIDEO_LAT-1] ? pix_reg : '0;
  assign hsync_o = hs_d[VIDEO_LAT-1];
  assign vsync_o = vs_d[VIDEO_LAT-1];

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural RAM macro.
// Expected values come from hand tables and a small timing model.
module tb_vram_arbiter;
  import vga_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        p_tick;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        h_sync;
  logic        v_sync;
  logic        host_req;
  logic        host_we;
  logic [16:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_gnt;
  logic        host_rvalid;
  logic [7:0]  host_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [16:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  rgb_o;
  logic        hsync_o;
  logic        vsync_o;

  logic [9:0]  ag_x;
  logic [9:0]  ag_y;
  logic [16:0] ag_addr;

  int n_cmp = 0;
  int n_bad = 0;
  int gx;
  int gy;
  bit wr_done = 1'b0;

  logic [7:0] mem [0:76799];

  always #5 clk_in = ~clk_in;

  vram_arbiter #(
    .FB_W(320), .FB_H(240), .ADDR_W(17), .DATA_W(8)
  ) dut (
    .clk_in(clk_in), .reset(reset), .p_tick(p_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .h_sync(h_sync), .v_sync(v_sync),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .rgb_o(rgb_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  fb_addr_gen u_ag (.pixel_x(ag_x), .pixel_y(ag_y), .addr(ag_addr));

  initial
    for (int i = 0; i < 76800; i++)
      mem[i] = 8'(i & 7);

  always @(posedge clk_in)
    if (ram_en && ram_addr < 17'd76800) begin
      if (ram_we)
        mem[ram_addr] = ram_wdata;
      else
        ram_rdata <= mem[ram_addr];
    end

  function automatic logic [7:0] exp_word(input int a);
    if (a == 321 && wr_done)
      return 8'hE0;
    return 8'(a & 7);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic gen_drive();
    pixel_x  = 10'(gx);
    pixel_y  = 10'(gy);
    video_on = (gx < H_ACTIVE) && (gy < V_ACTIVE);
    h_sync   = !(gx >= 656 && gx < 752);
    v_sync   = !(gy == 490 || gy == 491);
  endtask

  // Pixel count advances together with the tick, tick on the first clk.
  task automatic gen_step();
    if (!p_tick) begin
      gx++;
      if (gx == 800) begin
        gx = 0;
        gy = (gy == 524) ? 0 : gy + 1;
      end
      p_tick = 1'b1;
    end else begin
      p_tick = 1'b0;
    end
    gen_drive();
  endtask

  task automatic run_gen(input int y0, input int ncyc, output int hs_lo,
                         output int vs_lo, output int e0);
    logic h1, h2, v1, v2, o1, o2, s1, s2, g1, sl;
    logic [7:0] a1, a2, an, px;
    int miss, maxmiss;
    @(negedge clk_in);
    reset = 1'b1;
    gx = 0; gy = y0; p_tick = 1'b1;
    gen_drive();
    host_req = 1'b1; host_we = 1'b0; host_addr = 17'd321;
    @(negedge clk_in);
    chk("flush_hsync", hsync_o, 1);
    chk("flush_vsync", vsync_o, 1);
    chk("flush_rgb", rgb_o, 0);
    chk("flush_rvalid", host_rvalid, 0);
    reset = 1'b0;
    h1 = 1; h2 = 1; v1 = 1; v2 = 1; o1 = 0; o2 = 0;
    s1 = 0; s2 = 0; g1 = 0; a1 = 0; a2 = 0; px = 0;
    hs_lo = 0; vs_lo = 0; e0 = 0; miss = 0; maxmiss = 0;
    for (int n = 0; n <= ncyc; n++) begin
      if (n > 0) begin
        @(negedge clk_in);
        if (s2) px = a2;
        chk("hsync_align", hsync_o, h2);
        chk("vsync_align", vsync_o, v2);
        chk("rgb_pixel", rgb_o, o2 ? px : 8'h00);
        chk("run_rvalid", host_rvalid, g1);
        if (g1) chk("run_rdata", host_rdata, 8'hE0);
        if (!hsync_o) hs_lo++;
        if (!vsync_o) vs_lo++;
        if (rgb_o == 8'hE0) e0++;
        gen_step();
      end
      #1;
      sl = p_tick & video_on & ~pixel_x[0];
      chk("run_gnt", host_gnt, !sl);
      chk("run_ram_en", ram_en, 1);
      an = 8'h00;
      if (sl) begin
        chk("slot_addr", ram_addr, (gy >> 1) * 320 + (gx >> 1));
        an = exp_word((gy >> 1) * 320 + (gx >> 1));
      end
      miss = sl ? miss + 1 : 0;
      if (miss > maxmiss) maxmiss = miss;
      h2 = h1; h1 = h_sync; v2 = v1; v1 = v_sync;
      o2 = o1; o1 = video_on; s2 = s1; s1 = sl;
      a2 = a1; a1 = an; g1 = !sl;
    end
    chk("gnt_gap_le1", maxmiss <= 1, 1);
  endtask

  typedef struct {
    logic        pt, vo;
    logic [9:0]  x, y;
    logic        req, we;
    logic [16:0] addr;
    logic [7:0]  wd;
    logic        gnt, en, rwe;
    logic [16:0] raddr;
  } vec_t;

  typedef struct {
    logic [9:0]  x, y;
    logic [16:0] addr;
  } ag_t;

  vec_t vt[10];
  ag_t  at[8];
  int   hs, vs, e0;

  initial begin
    vt[0] = '{1, 1,   0,   0, 1, 0,    5, 8'h00, 0, 1, 0,     0};
    vt[1] = '{1, 1,   1,   0, 1, 0,    5, 8'h00, 1, 1, 0,     5};
    vt[2] = '{1, 1, 638, 479, 0, 0,    0, 8'h00, 0, 1, 0, 76799};
    vt[3] = '{1, 1, 639, 479, 1, 1, 76800, 8'h55, 1, 0, 0, 76800};
    vt[4] = '{1, 1,   2,   2, 0, 0,    0, 8'h00, 0, 1, 0,   321};
    vt[5] = '{0, 1,   2,   2, 1, 1,  321, 8'hE0, 1, 1, 1,   321};
    vt[6] = '{1, 0,   2,   2, 1, 0,   10, 8'h00, 1, 1, 0,    10};
    vt[7] = '{1, 1,   4,   3, 0, 0,    0, 8'h00, 0, 1, 0,   322};
    vt[8] = '{1, 1,   6,   0, 1, 1,  100, 8'h77, 0, 1, 0,     3};
    vt[9] = '{0, 0,   0,   0, 0, 0,    0, 8'h00, 0, 0, 0,     0};

    at[0] = '{  0,   0,     0};
    at[1] = '{  1,   0,     0};
    at[2] = '{639, 479, 76799};
    at[3] = '{  2,   2,   321};
    at[4] = '{  3,   3,   321};
    at[5] = '{100,  50,  8050};
    at[6] = '{638,   1,   319};
    at[7] = '{  0, 479, 76480};

    reset = 1'b1; p_tick = 1'b1; video_on = 1'b1;
    pixel_x = '0; pixel_y = '0; h_sync = 1'b0; v_sync = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 17'd5;
    host_wdata = '0; ag_x = '0; ag_y = '0;

    repeat (3) begin
      @(negedge clk_in);
      chk("rst_gnt", host_gnt, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_hsync", hsync_o, 1);
      chk("rst_vsync", vsync_o, 1);
      chk("rst_rgb", rgb_o, 0);
      chk("rst_rvalid", host_rvalid, 0);
      chk("rst_rdata", host_rdata, 0);
    end

    for (int i = 0; i < 8; i++) begin
      ag_x = at[i].x; ag_y = at[i].y;
      #1;
      chk($sformatf("addr_gen_%0d", i), ag_addr, at[i].addr);
    end

    h_sync = 1'b1; v_sync = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      reset = 1'b0;
      p_tick = vt[i].pt; video_on = vt[i].vo;
      pixel_x = vt[i].x; pixel_y = vt[i].y;
      host_req = vt[i].req; host_we = vt[i].we;
      host_addr = vt[i].addr; host_wdata = vt[i].wd;
      #1;
      chk($sformatf("vec%0d_gnt", i), host_gnt, vt[i].gnt);
      chk($sformatf("vec%0d_en", i), ram_en, vt[i].en);
      chk($sformatf("vec%0d_we", i), ram_we, vt[i].rwe);
      chk($sformatf("vec%0d_addr", i), ram_addr, vt[i].raddr);
    end
    wr_done = 1'b1;

    @(negedge clk_in);
    p_tick = 1'b0; video_on = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 17'd321;
    #1 chk("rd_gnt", host_gnt, 1);
    @(negedge clk_in);
    chk("rd_rvalid", host_rvalid, 1);
    chk("rd_rdata", host_rdata, 8'hE0);
    host_addr = 17'd76800;
    #1 chk("oob_rd_en", ram_en, 0);
    @(negedge clk_in);
    chk("oob_rvalid", host_rvalid, 1);
    chk("oob_rdata", host_rdata, 0);
    host_req = 1'b0;
    @(negedge clk_in);
    chk("rvalid_pulse", host_rvalid, 0);

    host_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        chk("b2b_rvalid", host_rvalid, 1);
        chk("b2b_rdata", host_rdata, exp_word(7 + i));
      end
      if (i < 3) host_addr = 17'(8 + i);
      else host_req = 1'b0;
      @(negedge clk_in);
    end
    chk("b2b_end", host_rvalid, 0);

    host_req = 1'b1; host_addr = 17'd13;
    @(negedge clk_in);
    chk("mid_rvalid", host_rvalid, 1);
    chk("mid_rdata", host_rdata, exp_word(13));
    reset = 1'b1;
    #1;
    chk("mid_gnt", host_gnt, 0);
    chk("mid_en", ram_en, 0);
    @(negedge clk_in);
    chk("mid_cancel", host_rvalid, 0);
    chk("mid_rdata0", host_rdata, 0);
    reset = 1'b0; host_req = 1'b0;

    run_gen(2, 1600, hs, vs, e0);
    chk("line2_e0_cycles", e0, 4);

    run_gen(478, 16 * 1600, hs, vs, e0);
    chk("hsync_low_cycles", hs, 16 * 192);
    chk("vsync_low_cycles", vs, 2 * 1600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
